// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state type
// and the supported operand-width range.
package mul_pkg;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_SIGN = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/add_n.sv
// Width-parametrised combinational adder with carry in and carry out,
// shared by the accumulate and negate steps of mul_seq.
module add_n #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   always_comb begin
      {cout, sum} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
   end

endmodule

// File: rtl/mul_seq.sv
// Sequential radix-2 shift-add multiplier, signed or unsigned per operation,
// with valid/ready handshakes on both the operand and product sides.
module mul_seq
   import mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               sgn,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p
);

   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_q, neg_d;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [PW-1:0]    add_x, add_y, add_sum;
   logic [PW-2:0]    add_lo;
   logic             add_cin, add_cout;

   // The most negative operand maps to 2^(WIDTH-1), which still fits unsigned.
   always_comb begin
      a_mag = (sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
      b_mag = (sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
   end

   // Low bits go through the adder; the top bit is rebuilt from its carry.
   add_n #(.WIDTH(PW - 1)) u_add (
      .x    (add_x[PW-2:0]),
      .y    (add_y[PW-2:0]),
      .cin  (add_cin),
      .sum  (add_lo),
      .cout (add_cout)
   );

   assign add_sum = {add_x[PW-1] ^ add_y[PW-1] ^ add_cout, add_lo};

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      add_x    = acc_q;
      add_y    = '0;
      add_cin  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               mcand_d  = PW'(a_mag);
               mplier_d = b_mag;
               neg_d    = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = ST_CALC;
            end
         end
         ST_CALC: begin
            add_y    = mplier_q[0] ? mcand_q : '0;
            acc_d    = add_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = ST_SIGN;
            end
         end
         ST_SIGN: begin
            if (neg_q) begin
               add_x   = ~acc_q;
               add_cin = 1'b1;
               acc_d   = add_sum;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign p         = acc_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq at WIDTH=8, plus a short random
// run against a behavioural product model.
module tb_mul_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        sgn;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] p;

   int checks = 0;
   int errors = 0;

   mul_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sgn       (sgn),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
      logic signed [15:0] sx, sy;
      sx = s ? {{8{x[7]}}, x} : {8'h00, x};
      sy = s ? {{8{y[7]}}, y} : {8'h00, y};
      return 16'(sx * sy);
   endfunction

   // Waits for in_ready, transfers one operation, then scrambles the operand
   // inputs so a design that failed to capture them would be caught.
   task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic s, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         a = x; b = y; sgn = s; in_valid = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         a = ~x; b = ~y; sgn = ~s;
      end
   endtask

   // Counts negedges after the transfer edge until out_valid is seen.
   task automatic wait_valid(output int cyc, output bit timeout);
      cyc = 0;
      timeout = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         cyc++;
         if (out_valid) begin
            timeout = 1'b0;
            break;
         end
      end
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sgn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
      checks++;
      if (p !== 16'h0000) begin errors++; $display("[TB] FAIL reset_p got %h want 0000", p); end
   endtask

   task automatic test_directed();
      logic [24:0] vec [8] = '{
         {1'b0, 8'd13,  8'd11,  8'h8F},
         {1'b0, 8'hFF,  8'hFF,  8'h01},
         {1'b1, 8'hFD,  8'h05,  8'hF1},
         {1'b1, 8'h80,  8'h80,  8'h00},
         {1'b1, 8'h80,  8'h01,  8'h80},
         {1'b1, 8'h7F,  8'h80,  8'h80},
         {1'b0, 8'hFD,  8'h05,  8'hF1},
         {1'b0, 8'h80,  8'h80,  8'h00}
      };
      logic [15:0] want [8] = '{16'h008F, 16'hFE01, 16'hFFF1, 16'h4000,
                                16'hFF80, 16'hC080, 16'h04F1, 16'h4000};
      bit ok, tmo;
      int cyc;
      for (int i = 0; i < 8; i++) begin
         issue(vec[i][23:16], vec[i][15:8], vec[i][24], ok);
         checks++;
         if (!ok) begin errors++; $display("[TB] FAIL dir%0d_accept got timeout want in_ready", i); continue; end
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_busy_in_ready got %b want 0", i, in_ready); end
         wait_valid(cyc, tmo);
         checks++;
         if (tmo) begin errors++; $display("[TB] FAIL dir%0d_out_valid got timeout want valid", i); continue; end
         checks++;
         if (cyc !== 10) begin errors++; $display("[TB] FAIL dir%0d_latency got %0d want 10", i, cyc); end
         checks++;
         if (p !== want[i]) begin errors++; $display("[TB] FAIL dir%0d_product got %h want %h", i, p, want[i]); end
         pop();
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dir%0d_return_idle got rdy=%b vld=%b want rdy=1 vld=0", i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok, tmo;
      int cyc;
      issue(8'h12, 8'h34, 1'b0, ok);
      wait_valid(cyc, tmo);
      checks++;
      if (!ok || tmo) begin errors++; $display("[TB] FAIL bp_setup got ok=%b tmo=%b want ok=1 tmo=0", ok, tmo); return; end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || p !== 16'h03A8) begin
            errors++;
            $display("[TB] FAIL bp_hold%0d got vld=%b p=%h want vld=1 p=03a8", i, out_valid, p);
         end
      end
      pop();
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_next_ready got %b want 1", in_ready); end
      issue(8'h0A, 8'hF6, 1'b1, ok);
      wait_valid(cyc, tmo);
      checks++;
      if (!ok || tmo || p !== 16'hFF9C) begin
         errors++;
         $display("[TB] FAIL b2b_product got p=%h ok=%b tmo=%b want ff9c", p, ok, tmo);
      end
      pop();
   endtask

   task automatic test_ignore_busy();
      bit ok, tmo;
      int cyc;
      int seen;
      issue(8'd7, 8'd9, 1'b0, ok);
      repeat (2) @(negedge clk);
      a = 8'd200; b = 8'd200; sgn = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_valid(cyc, tmo);
      checks++;
      if (!ok || tmo) begin errors++; $display("[TB] FAIL busy_valid got ok=%b tmo=%b want ok=1 tmo=0", ok, tmo); return; end
      checks++;
      if (cyc + 2 !== 10) begin errors++; $display("[TB] FAIL busy_latency got %0d want 10", cyc + 2); end
      checks++;
      if (p !== 16'h003F) begin errors++; $display("[TB] FAIL busy_product got %h want 003f", p); end
      pop();
      seen = 0;
      repeat (14) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("[TB] FAIL busy_no_extra got %0d valid cycles want 0", seen); end
   endtask

   task automatic test_reset_mid();
      bit ok, tmo;
      int cyc;
      int seen;
      issue(8'h55, 8'h33, 1'b0, ok);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (!ok || in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL midrst_state got rdy=%b vld=%b p=%h want rdy=1 vld=0 p=0000", in_ready, out_valid, p);
      end
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("[TB] FAIL midrst_stale got %0d valid cycles want 0", seen); end
      issue(8'd3, 8'd4, 1'b0, ok);
      wait_valid(cyc, tmo);
      checks++;
      if (!ok || tmo || p !== 16'h000C) begin
         errors++;
         $display("[TB] FAIL midrst_recover got p=%h ok=%b tmo=%b want 000c", p, ok, tmo);
      end
      pop();
   endtask

   task automatic test_random();
      logic [15:0] sb [$];
      logic [15:0] exp_p;
      logic [7:0]  x, y;
      logic        s;
      int          issued = 0;
      int          received = 0;
      bit          ok, got;
      for (int n = 0; n < 400; n++) begin
         x = 8'($urandom);
         y = 8'($urandom);
         s = 1'($urandom);
         issue(x, y, s, ok);
         if (!ok) begin
            checks++; errors++;
            $display("[TB] FAIL rnd%0d_accept got timeout want in_ready", n);
            break;
         end
         sb.push_back(model(x, y, s));
         issued++;
         got = 1'b0;
         for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
               exp_p = sb.pop_front();
               checks++;
               if (p !== exp_p) begin
                  errors++;
                  $display("[TB] FAIL rnd%0d_product a=%h b=%h s=%b got %h want %h", n, x, y, s, p, exp_p);
               end
               received++;
               got = 1'b1;
               @(posedge clk);
               #1;
               out_ready = 1'b0;
               break;
            end
         end
         out_ready = 1'b0;
         if (!got) begin
            checks++; errors++;
            $display("[TB] FAIL rnd%0d_result got timeout want product", n);
            break;
         end
      end
      checks++;
      if (received !== issued || sb.size() !== 0) begin
         errors++;
         $display("[TB] FAIL rnd_count got %0d results want %0d", received, issued);
      end
   endtask

   initial begin
      $display("[TB] starting mul_seq bench");
      test_reset();
      test_directed();
      test_back_to_back();
      test_ignore_busy();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
